bch_data_pack: RTL

- Downstream stage of the serial BCH decoder. Takes the corrected message bits, one per cycle, and packs them into W-bit parallel words.
- Words are pushed into a small FIFO with a valid/ready output handshake.
- The decoder offers no backpressure, so this block absorbs stalls and flags any word it has to drop.
- Marks the last word of every K-bit codeword message and reports how many valid bits that word holds.

---
 rtl/bch_data_pack.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bch_data_pack.sv
// Serial-to-parallel packer for decoded BCH message bits.
// A registered FWFT FIFO sits on the word output and drops words when full.
module bch_data_pack #(
  parameter int K     = 5,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int NB   = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [NB-1:0] out_nbits,
  output logic          overflow,
  input  logic          overflow_clr
);

  localparam int FW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FW-1:0] fcnt;
  logic [WW-1:0] wcnt;
  logic [W-1:0]  asm_q;

  logic [W-1:0]  word_new;
  logic          last_new;
  logic [NB-1:0] nbits_new;
  logic          done;

  logic [W-1:0]  mem_data  [DEPTH];
  logic          mem_last  [DEPTH];
  logic [NB-1:0] mem_nbits [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic          pop, push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    word_new       = asm_q;
    word_new[wcnt] = in_data;
    last_new       = (fcnt == FW'(K - 1));
    done           = in_valid && ((wcnt == WW'(W - 1)) || last_new);
    nbits_new      = NB'(wcnt) + NB'(1);
    pop            = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_ok        = done && ((count != CW'(DEPTH)) || pop);
    rd_ptr_n       = pop ? ptr_inc(rd_ptr) : rd_ptr;
    count_n        = count + CW'(push_ok) - CW'(pop);
  end

  // Stage p0: bit assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      wcnt  <= '0;
      asm_q <= '0;
    end else if (in_valid) begin
      if (done) begin
        wcnt  <= '0;
        asm_q <= '0;
      end else begin
        wcnt  <= wcnt + WW'(1);
        asm_q <= word_new;
      end
      fcnt <= last_new ? '0 : fcnt + FW'(1);
    end
  end

  // Stage p1: FIFO storage and registered head
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr]  <= word_new;
      mem_last[wr_ptr]  <= last_new;
      mem_nbits[wr_ptr] <= nbits_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_nbits <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != '0);
      // Head entry being written this edge is not in memory yet; bypass it.
      if (count_n != '0) begin
        if (push_ok && (wr_ptr == rd_ptr_n)) begin
          out_data  <= word_new;
          out_last  <= last_new;
          out_nbits <= nbits_new;
        end else begin
          out_data  <= mem_data[rd_ptr_n];
          out_last  <= mem_last[rd_ptr_n];
          out_nbits <= mem_nbits[rd_ptr_n];
        end
      end
      if (done && !push_ok) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule
